// File: rtl/scan_chain_loader.sv
// Scan chain initiator: serialises host bytes onto scan_in (LSB first) while
// capturing the chain's old contents from scan_out, and gates the core's proc_en.
module scan_chain_loader #(
  parameter int CHAIN_LEN = 288
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_start,
  input  logic       cmd_run,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       scan_enable,
  output logic       scan_in,
  input  logic       scan_out,
  output logic       proc_en,
  input  logic       halt,
  output logic       busy,
  output logic       done
);

  localparam int NBYTES     = (CHAIN_LEN + 7) / 8;
  localparam int BCW        = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int LAST_NBITS = (CHAIN_LEN % 8 == 0) ? 8 : (CHAIN_LEN % 8);

  localparam logic [BCW-1:0] LAST_BYTE     = BCW'(NBYTES - 1);
  localparam logic [2:0]     LAST_BIT_FULL = 3'd7;
  localparam logic [2:0]     LAST_BIT_PART = 3'(LAST_NBITS - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SHIFT = 3'd2,
    EMIT  = 3'd3,
    RUN   = 3'd4
  } stateT;

  stateT          state_q, state_d;
  logic [7:0]     shiftByte_q, shiftByte_d;
  logic [7:0]     readback_q, readback_d;
  logic [2:0]     bitIdx_q, bitIdx_d;
  logic [BCW-1:0] byteCnt_q, byteCnt_d;
  logic [2:0]     lastBit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      shiftByte_q <= 8'd0;
      readback_q  <= 8'd0;
      bitIdx_q    <= 3'd0;
      byteCnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      shiftByte_q <= shiftByte_d;
      readback_q  <= readback_d;
      bitIdx_q    <= bitIdx_d;
      byteCnt_q   <= byteCnt_d;
    end
  end

  // A partial final byte shifts only its low bits; the rest of readback stays 0.
  assign lastBit = (byteCnt_q == LAST_BYTE) ? LAST_BIT_PART : LAST_BIT_FULL;

  always_comb begin
    state_d     = state_q;
    shiftByte_d = shiftByte_q;
    readback_d  = readback_q;
    bitIdx_d    = bitIdx_q;
    byteCnt_d   = byteCnt_q;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    scan_enable = 1'b0;
    scan_in     = 1'b0;
    proc_en     = 1'b0;
    done        = 1'b0;

    case (state_q)
      IDLE: begin
        if (cmd_start) begin
          state_d   = LOAD;
          byteCnt_d = '0;
        end else if (cmd_run) begin
          state_d = RUN;
        end
      end

      LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          shiftByte_d = in_data;
          readback_d  = 8'd0;
          bitIdx_d    = 3'd0;
          state_d     = SHIFT;
        end
      end

      SHIFT: begin
        scan_enable          = 1'b1;
        scan_in              = shiftByte_q[bitIdx_q];
        readback_d[bitIdx_q] = scan_out;
        if (bitIdx_q == lastBit) begin
          state_d = EMIT;
        end else begin
          bitIdx_d = bitIdx_q + 3'd1;
        end
      end

      EMIT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (byteCnt_q == LAST_BYTE) begin
            done    = 1'b1;
            state_d = IDLE;
          end else begin
            byteCnt_d = byteCnt_q + 1'b1;
            state_d   = LOAD;
          end
        end
      end

      RUN: begin
        proc_en = 1'b1;
        if (cmd_start) begin
          state_d   = LOAD;
          byteCnt_d = '0;
        end else if (halt) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign out_data = readback_q;
  assign busy     = (state_q != IDLE) && (state_q != RUN);

endmodule

// File: tb/tb_scan_chain_loader.sv
// Bench for scan_chain_loader: a 16-bit and a 12-bit instance, each driving a
// behavioural shift-register chain, checked against image-level expectations.
module tb_scan_chain_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, cmdStart, cmdRun, inValid, outReady, halt, sel;
  logic [7:0] inData;
  logic [1:0] inReadyV, outValidV, scanEnV, scanInV, procEnV, busyV, doneV;
  logic [7:0] outDataA, outDataB;
  logic [15:0] chainA;
  logic [11:0] chainB;
  logic        preA = 1'b0, preB = 1'b0, cntClr = 1'b0;
  logic [15:0] preVal = 16'd0;
  int          seCnt = 0, doneCnt = 0, overlapCnt = 0;
  int          vectors = 0, miscompares = 0;
  int          chainLen = 16;
  logic [15:0] expImg;

  scan_chain_loader #(.CHAIN_LEN(16)) u16 (
    .clk(clk), .rst(rst), .cmd_start(cmdStart & ~sel), .cmd_run(cmdRun & ~sel),
    .in_data(inData), .in_valid(inValid & ~sel), .in_ready(inReadyV[0]),
    .out_data(outDataA), .out_valid(outValidV[0]), .out_ready(outReady & ~sel),
    .scan_enable(scanEnV[0]), .scan_in(scanInV[0]), .scan_out(chainA[0]),
    .proc_en(procEnV[0]), .halt(halt & ~sel), .busy(busyV[0]), .done(doneV[0])
  );

  scan_chain_loader #(.CHAIN_LEN(12)) u12 (
    .clk(clk), .rst(rst), .cmd_start(cmdStart & sel), .cmd_run(cmdRun & sel),
    .in_data(inData), .in_valid(inValid & sel), .in_ready(inReadyV[1]),
    .out_data(outDataB), .out_valid(outValidV[1]), .out_ready(outReady & sel),
    .scan_enable(scanEnV[1]), .scan_in(scanInV[1]), .scan_out(chainB[0]),
    .proc_en(procEnV[1]), .halt(halt & sel), .busy(busyV[1]), .done(doneV[1])
  );

  wire        inReady  = inReadyV[sel];
  wire        outValid = outValidV[sel];
  wire        scanEn   = scanEnV[sel];
  wire        procEn   = procEnV[sel];
  wire        busy     = busyV[sel];
  wire        done     = doneV[sel];
  wire [7:0]  outData  = sel ? outDataB : outDataA;
  wire [15:0] curChain = sel ? {4'd0, chainB} : chainA;

  // Behavioural chains: scan_in enters at the head, scan_out is bit 0 (the tail).
  always @(posedge clk) begin
    if (preA) chainA <= preVal;
    else if (scanEnV[0]) chainA <= {scanInV[0], chainA[15:1]};
    if (preB) chainB <= preVal[11:0];
    else if (scanEnV[1]) chainB <= {scanInV[1], chainB[11:1]};
  end

  always @(posedge clk) begin
    if (cntClr) begin
      seCnt   <= 0;
      doneCnt <= 0;
    end else begin
      if (scanEnV[sel]) seCnt <= seCnt + 1;
      if (doneV[sel]) doneCnt <= doneCnt + 1;
    end
    if ((scanEnV & procEnV) != 2'b00) overlapCnt <= overlapCnt + 1;
  end

  function automatic logic [15:0] lenMask();
    logic [16:0] m;
    m = (17'd1 << chainLen) - 17'd1;
    return m[15:0];
  endfunction

  function automatic logic [7:0] bitMask(input int n);
    logic [8:0] m;
    m = (9'd1 << n) - 9'd1;
    return m[7:0];
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic selectDut(input logic s);
    sel      = s;
    chainLen = s ? 12 : 16;
  endtask

  task automatic preloadChain(input logic [15:0] v);
    preVal = v;
    if (sel) preB = 1'b1;
    else preA = 1'b1;
    @(negedge clk);
    preA   = 1'b0;
    preB   = 1'b0;
    expImg = v & lenMask();
  endtask

  // One full load/readback; the model expects the old image out and the new image in.
  task automatic applyStimulus(input logic [7:0] b0, input logic [7:0] b1,
                               input int stallIn, input int stallOut,
                               input bit poke, input bit withRun);
    logic [7:0]  bytes [2];
    logic [15:0] newImg, sh;
    logic [7:0]  expRd;
    int          nbits, cnt, w;
    bytes[0] = b0;
    bytes[1] = b1;
    newImg   = {b1, b0} & lenMask();
    cntClr   = 1'b1;
    cmdStart = 1'b1;
    cmdRun   = withRun;
    @(negedge clk);
    cntClr   = 1'b0;
    cmdStart = 1'b0;
    cmdRun   = 1'b0;
    checkOutput("start_busy", busy, 1);
    checkOutput("start_proc_en", procEn, 0);
    for (int i = 0; i < 2; i++) begin
      nbits = (i == 1 && (chainLen % 8) != 0) ? (chainLen % 8) : 8;
      for (int s = 0; s < stallIn; s++) begin
        checkOutput("load_stall_scan_enable", scanEn, 0);
        @(negedge clk);
      end
      inValid = 1'b1;
      inData  = bytes[i];
      w = 0;
      while (!inReady && w < 20) begin
        @(negedge clk);
        w++;
      end
      checkOutput("in_ready", inReady, 1);
      @(negedge clk);
      inValid = 1'b0;
      inData  = 8'($urandom);
      checkOutput("first_scan_enable", scanEn, 1);
      cnt = 0;
      w   = 0;
      while (scanEn && w < 20) begin
        cnt++;
        if (poke && i == 0 && cnt == 3) begin
          cmdStart = 1'b1;
          cmdRun   = 1'b1;
        end
        @(negedge clk);
        cmdStart = 1'b0;
        cmdRun   = 1'b0;
        w++;
      end
      checkOutput("shift_cycles", cnt, nbits);
      checkOutput("proc_en_while_loading", procEn, 0);
      checkOutput("out_valid", outValid, 1);
      sh    = expImg >> (8 * i);
      expRd = sh[7:0] & bitMask(nbits);
      for (int s = 0; s < stallOut; s++) begin
        checkOutput("emit_stall_data", outData, expRd);
        checkOutput("emit_stall_scan_enable", scanEn, 0);
        @(negedge clk);
      end
      outReady = 1'b1;
      #1;
      checkOutput("readback_byte", outData, expRd);
      checkOutput("done_pulse", done, (i == 1) ? 1 : 0);
      @(negedge clk);
      outReady = 1'b0;
    end
    checkOutput("done_after", done, 0);
    checkOutput("idle_busy", busy, 0);
    checkOutput("chain_image", curChain, newImg);
    checkOutput("scan_enable_total", seCnt, chainLen);
    checkOutput("done_count", doneCnt, 1);
    expImg = newImg;
  endtask

  initial begin
    logic [15:0] img;
    logic [7:0]  r0, r1;
    rst = 1'b1; cmdStart = 1'b0; cmdRun = 1'b0; inValid = 1'b0; outReady = 1'b0;
    halt = 1'b0; inData = 8'd0;
    selectDut(1'b0);
    #2;
    checkOutput("reset_outputs_16", {inReadyV[0], outValidV[0], scanEnV[0], scanInV[0],
                procEnV[0], busyV[0], doneV[0], outDataA}, 0);
    checkOutput("reset_outputs_12", {inReadyV[1], outValidV[1], scanEnV[1], scanInV[1],
                procEnV[1], busyV[1], doneV[1], outDataB}, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] directed 16-bit and 12-bit loads");
    preloadChain(16'hBEEF);
    applyStimulus(8'h34, 8'h12, 0, 0, 0, 0);
    selectDut(1'b1);
    preloadChain(16'h0ABC);
    applyStimulus(8'hFF, 8'h05, 0, 0, 0, 0);

    $display("[TB] back-pressure against an unstalled reference load");
    selectDut(1'b0);
    img = 16'($urandom);
    r0  = 8'($urandom);
    r1  = 8'($urandom);
    preloadChain(img);
    applyStimulus(r0, r1, 0, 0, 0, 0);
    preloadChain(img);
    applyStimulus(r0, r1, 5, 10, 0, 0);

    $display("[TB] run control");
    cmdRun = 1'b1;
    @(negedge clk);
    cmdRun = 1'b0;
    checkOutput("run_proc_en", procEn, 1);
    checkOutput("run_busy", busy, 0);
    @(negedge clk);
    halt = 1'b1;
    @(negedge clk);
    halt = 1'b0;
    checkOutput("halt_proc_en", procEn, 0);
    checkOutput("halt_busy", busy, 0);
    cmdRun = 1'b1;
    @(negedge clk);
    cmdRun = 1'b0;
    checkOutput("rerun_proc_en", procEn, 1);
    cmdRun = 1'b1;
    @(negedge clk);
    cmdRun = 1'b0;
    checkOutput("run_ignores_cmd_run", procEn, 1);
    preloadChain(16'h5A5A);
    checkOutput("run_held_during_preload", procEn, 1);
    applyStimulus(8'hC3, 8'h3C, 0, 0, 0, 0);
    selectDut(1'b1);
    preloadChain(16'h0123);
    applyStimulus(8'h9E, 8'h07, 0, 0, 0, 1);

    $display("[TB] reset during shift");
    selectDut(1'b0);
    preloadChain(16'h7E81);
    cmdStart = 1'b1;
    @(negedge clk);
    cmdStart = 1'b0;
    inValid  = 1'b1;
    inData   = 8'hA5;
    @(negedge clk);
    inValid = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("pre_reset_shifting", scanEn, 1);
    #2 rst = 1'b1;
    #1;
    checkOutput("async_reset_outputs", {inReady, outValid, scanEn, scanInV[0], procEn, busy,
                done, outData}, 0);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("post_reset_busy", busy, 0);
    preloadChain(16'h1F2E);
    applyStimulus(8'h66, 8'h99, 0, 0, 0, 0);

    $display("[TB] commands during shift and randomized loads");
    selectDut(1'b1);
    preloadChain(16'h0D4B);
    applyStimulus(8'h5C, 8'h0E, 0, 0, 1, 0);
    for (int k = 0; k < 8; k++) begin
      selectDut(k[0]);
      preloadChain(16'($urandom));
      applyStimulus(8'($urandom), 8'($urandom), int'($urandom_range(0, 4)),
                    int'($urandom_range(0, 4)), bit'($urandom_range(0, 1)), 1'b0);
    end

    checkOutput("scan_enable_with_proc_en", overlapCnt, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
